rx_fifo: RTL

- Receive buffer directly downstream of the UART receiver.
- Captures each completed frame (rx_dout plus the parity-good flag `correct`) on the rising edge of rx_done. Holds frames in a circular buffer until the host reads them.
- Reports occupancy, a sticky overflow flag and a saturating parity-error count.
- All inputs are synchronous to clk; the receiver's outputs are already registered in the clk domain before reaching this block.

---
 rtl/rx_fifo_if.sv | 30 +++
 rtl/rx_fifo.sv | 110 +++++++++++
 2 files changed

// File: rtl/rx_fifo_if.sv
// Host/receiver-facing signal bundle for rx_fifo.
// The master side is the receiver plus the host; the slave side is the FIFO.
interface rx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic [DATA_BITS-1:0]  rx_dout;
  logic                  rx_done;
  logic                  correct;
  logic                  rd_en;
  logic                  clr_status;
  logic [DATA_BITS-1:0]  dout;
  logic                  dout_perr;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic [7:0]            perr_cnt;

  modport master (
    output rx_dout, rx_done, correct, rd_en, clr_status,
    input  dout, dout_perr, rd_valid, empty, full, count, overflow, perr_cnt
  );

  modport slave (
    input  rx_dout, rx_done, correct, rd_en, clr_status,
    output dout, dout_perr, rd_valid, empty, full, count, overflow, perr_cnt
  );
endinterface

// File: rtl/rx_fifo.sv
// Receive buffer behind the UART receiver: captures {~correct, rx_dout} on
// each rising edge of rx_done, serves host reads with one-cycle latency,
// and tracks occupancy, a sticky overflow flag and a saturating parity-error
// count. Parameters must match those of the connected rx_fifo_if instance.
module rx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic     clk,
  input  logic     reset,
  rx_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_BITS:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_rx_done_q;
  logic [DATA_BITS-1:0]  r_dout;
  logic                  r_dout_perr;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic [7:0]            r_perr_cnt;

  logic w_empty;
  logic w_full;
  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_perr_push;

  // Handshake decode: a full buffer still accepts a frame when a read frees a slot
  always_comb begin
    w_empty     = (r_count == '0);
    w_full      = (r_count == C_DEPTH);
    w_push_req  = bus.rx_done & ~r_rx_done_q;
    w_pop       = bus.rd_en & ~w_empty;
    w_push      = w_push_req & (~w_full | w_pop);
    w_drop      = w_push_req & w_full & ~w_pop;
    w_perr_push = w_push & ~bus.correct;
  end

  // Frame storage; contents are don't-care after reset so no reset here
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= {~bus.correct, bus.rx_dout};
    end
  end

  // Pointers, occupancy, edge detector and registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rx_done_q <= 1'b1;
      r_dout      <= '0;
      r_dout_perr <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rx_done_q <= bus.rx_done;
      r_rd_valid  <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        {r_dout_perr, r_dout} <= r_mem[r_rd_ptr];
        r_rd_ptr              <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Status: a same-cycle set/increment takes precedence over clr_status
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_perr_cnt <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_status) begin
        r_overflow <= 1'b0;
      end
      if (bus.clr_status) begin
        r_perr_cnt <= w_perr_push ? 8'd1 : 8'd0;
      end else if (w_perr_push && (r_perr_cnt != '1)) begin
        r_perr_cnt <= r_perr_cnt + 8'd1;
      end
    end
  end

  assign bus.dout      = r_dout;
  assign bus.dout_perr = r_dout_perr;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.perr_cnt  = r_perr_cnt;

endmodule
